// File: rtl/arc4_pkg.sv
// -----------------------------------------------------------------------------
// arc4_pkg
//   Shared types for the ARC4 S-array initialiser: the controller state
//   encoding and the request mode encoding.
//   Build option: ARC4_SBOX_KSA_EN (see arc4_sbox_init) decides whether the
//   KSA states are reachable; the enum always lists them so encodings stay
//   stable between builds.
// -----------------------------------------------------------------------------
package arc4_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      RD_I,
      GOT_I,
      GOT_J,
      WR_I,
      WR_J
   } state_t;

   localparam logic MODE_FILL = 1'b0;   // identity fill only
   localparam logic MODE_KSA  = 1'b1;   // identity fill followed by key schedule

endpackage

// File: rtl/arc4_sbox_init.sv
// -----------------------------------------------------------------------------
// arc4_sbox_init
//   Fills an external single-port synchronous S memory with the identity
//   permutation and, in KSA mode, runs the ARC4 key-scheduling swap pass.
//   One request per en/rdy handshake.
//
//   Build option: define ARC4_SBOX_KSA_EN to include the key-schedule pass.
//   Without it, mode and key are ignored and every request is a plain fill.
//
// Parameters
//   ADDR_W     S address width; DEPTH = 2**ADDR_W; data and j are ADDR_W wide
//   KEY_BYTES  key length in ADDR_W-bit symbols (1 is legal)
//
// Ports
//   clk     system clock
//   rst     synchronous, active-high reset; aborts any run in progress
//   en      start request, accepted only while rdy=1
//   rdy     1 = idle, will accept en
//   mode    MODE_FILL / MODE_KSA, latched with en
//   key     key; symbol 0 is the most significant ADDR_W bits; latched with en
//   addr    memory address
//   wrdata  memory write data
//   wren    memory write enable
//   q       memory read data, valid the cycle after addr is presented
// -----------------------------------------------------------------------------
module arc4_sbox_init
   import arc4_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int KEY_BYTES = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   output logic                        rdy,
   input  logic                        mode,
   input  logic [KEY_BYTES*ADDR_W-1:0] key,
   output logic [ADDR_W-1:0]           addr,
   output logic [ADDR_W-1:0]           wrdata,
   output logic                        wren,
   input  logic [ADDR_W-1:0]           q
);

   localparam int KEY_W = KEY_BYTES * ADDR_W;
   localparam int KI_W  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] i;
   logic              last_i;

   assign last_i = (i == {ADDR_W{1'b1}});

`ifdef ARC4_SBOX_KSA_EN
   logic              mode_r;
   logic [KEY_W-1:0]  key_r;
   logic [KEY_W-1:0]  key_shift;
   logic [KI_W-1:0]   kidx;      // i mod KEY_BYTES, kept as its own wrapping counter
   logic [ADDR_W-1:0] key_sym;
   logic [ADDR_W-1:0] j;
   logic [ADDR_W-1:0] j_sum;
   logic [ADDR_W-1:0] si;
   logic [ADDR_W-1:0] sj;

   // Bring symbol kidx to the top of the key word instead of building a mux
   // indexed by a counter that may be wider than the symbol count.
   assign key_shift = key_r << (int'(kidx) * ADDR_W);
   assign key_sym   = key_shift[KEY_W-1 -: ADDR_W];
   // q holds S[i] during GOT_I; the sum wraps at ADDR_W bits.
   assign j_sum     = j + q + key_sym;
`else
   logic unused_ok;
   assign unused_ok = ^{mode, key, q};
`endif

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      // NOTE: every output and the next state get a default before the case,
      // so no path through the block can leave one unassigned (no latches).
      state_nx = state;
      rdy      = 1'b0;
      wren     = 1'b0;
      addr     = '0;
      wrdata   = '0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (en) state_nx = FILL;
         end
         FILL: begin
            addr   = i;
            wrdata = i;
            wren   = 1'b1;
`ifdef ARC4_SBOX_KSA_EN
            if (last_i) state_nx = (mode_r == MODE_KSA) ? RD_I : IDLE;
`else
            if (last_i) state_nx = IDLE;
`endif
         end
`ifdef ARC4_SBOX_KSA_EN
         RD_I: begin
            addr     = i;
            state_nx = GOT_I;
         end
         GOT_I: begin
            // Present the new j in the same cycle S[i] arrives so S[j] is
            // back on q one cycle later; this is the only q-to-addr path.
            addr     = j_sum;
            state_nx = GOT_J;
         end
         GOT_J: begin
            addr     = j;
            state_nx = WR_I;
         end
         WR_I: begin
            addr     = i;
            wrdata   = sj;
            wren     = 1'b1;
            state_nx = WR_J;
         end
         WR_J: begin
            // When i==j this rewrites the same location with the same value.
            addr     = j;
            wrdata   = si;
            wren     = 1'b1;
            state_nx = last_i ? IDLE : RD_I;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i      <= '0;
`ifdef ARC4_SBOX_KSA_EN
         j      <= '0;
         kidx   <= '0;
         si     <= '0;
         sj     <= '0;
         mode_r <= MODE_FILL;
         key_r  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  i      <= '0;
`ifdef ARC4_SBOX_KSA_EN
                  mode_r <= mode;
                  key_r  <= key;
`endif
               end
            end
            FILL: begin
               i <= i + ADDR_W'(1);   // wraps to 0 after the last fill write
`ifdef ARC4_SBOX_KSA_EN
               if (last_i) begin
                  j    <= '0;
                  kidx <= '0;
               end
`endif
            end
`ifdef ARC4_SBOX_KSA_EN
            GOT_I: begin
               si <= q;
               j  <= j_sum;
            end
            GOT_J: sj <= q;
            WR_J: begin
               i    <= i + ADDR_W'(1);
               kidx <= (kidx == KI_W'(KEY_BYTES - 1)) ? '0 : kidx + KI_W'(1);
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_arc4_sbox_init.sv
// -----------------------------------------------------------------------------
// tb_arc4_sbox_init
//   Two instances: 256-entry / 3-symbol key and 16-entry / 1-symbol key, each
//   with a behavioural single-port synchronous RAM. A software ARC4 model
//   produces the expected write stream per request; monitors compare every
//   memory write against it. Honours ARC4_SBOX_KSA_EN the same way the design
//   does (mode=1 acts as a plain fill when it is not defined).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arc4_sbox_init;

`ifdef ARC4_SBOX_KSA_EN
   localparam bit KSA_BUILD = 1'b1;
`else
   localparam bit KSA_BUILD = 1'b0;
`endif

   typedef struct {
      int a;
      int d;
   } wr_t;

   logic clk = 1'b0;
   logic rst;

   // 256-entry instance
   logic        en, mode, rdy, wren;
   logic [23:0] key;
   logic [7:0]  addr, wrdata, q;
   logic [7:0]  mem8 [256];
   wr_t         exp8_q [$];
   wr_t         w8;

   // 16-entry instance
   logic        en4, mode4, rdy4, wren4;
   logic [3:0]  key4, addr4, wrdata4, q4;
   logic [3:0]  mem4 [16];
   wr_t         exp4_q [$];
   wr_t         w4;

   wr_t         mdl_wr [$];
   int          mdl_s [256];
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   arc4_sbox_init #(.ADDR_W(8), .KEY_BYTES(3)) u_dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy), .mode(mode), .key(key),
      .addr(addr), .wrdata(wrdata), .wren(wren), .q(q)
   );

   arc4_sbox_init #(.ADDR_W(4), .KEY_BYTES(1)) u_dut4 (
      .clk(clk), .rst(rst), .en(en4), .rdy(rdy4), .mode(mode4), .key(key4),
      .addr(addr4), .wrdata(wrdata4), .wren(wren4), .q(q4)
   );

   // Single-port synchronous RAMs: read data is the old contents, one cycle late.
   always @(posedge clk) begin
      if (wren) mem8[addr] <= wrdata;
      q <= mem8[addr];
   end

   always @(posedge clk) begin
      if (wren4) mem4[addr4] <= wrdata4;
      q4 <= mem4[addr4];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Software ARC4: identity fill, then the key-scheduling swap pass. Records
   // every memory write the engine is expected to make, and the final array.
   task automatic ksa_model(input int depth, input int nk, input int ks[3], input bit ksa);
      int s [256];
      int j, t;
      mdl_wr.delete();
      for (int k = 0; k < depth; k++) begin
         s[k] = k;
         mdl_wr.push_back('{k, k});
      end
      if (ksa) begin
         j = 0;
         for (int k = 0; k < depth; k++) begin
            j = (j + s[k] + ks[k % nk]) % depth;
            mdl_wr.push_back('{k, s[j]});
            mdl_wr.push_back('{j, s[k]});
            t    = s[k];
            s[k] = s[j];
            s[j] = t;
         end
      end
      mdl_s = s;
   endtask

   // Monitors: every write the DUT presents must be the next expected one.
   always @(negedge clk) begin
      if (!rst && wren) begin
         check("w8_pending", 32'(exp8_q.size() > 0), 1);
         if (exp8_q.size() > 0) begin
            w8 = exp8_q.pop_front();
            check("w8_addr", 32'(addr), w8.a);
            check("w8_data", 32'(wrdata), w8.d);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && wren4) begin
         check("w4_pending", 32'(exp4_q.size() > 0), 1);
         if (exp4_q.size() > 0) begin
            w4 = exp4_q.pop_front();
            check("w4_addr", 32'(addr4), w4.a);
            check("w4_data", 32'(wrdata4), w4.d);
         end
      end
   end

   task automatic wait_busy(input bit sel4, output int n);
      n = 0;
      @(negedge clk);
      while (((sel4 ? rdy4 : rdy) !== 1'b1) && n < 4000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic start8(input bit m, input logic [23:0] k, input bit hold);
      int ks [3];
      int n = 0;
      while (rdy !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("start8_rdy", 32'(rdy), 1);
      ks = '{int'(k[23:16]), int'(k[15:8]), int'(k[7:0])};
      ksa_model(256, 3, ks, m && KSA_BUILD);
      foreach (mdl_wr[x]) exp8_q.push_back(mdl_wr[x]);
      mode = m;
      key  = k;
      en   = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) en = 1'b0;
   endtask

   task automatic finish8(input bit m);
      int n, dup;
      int seen [256];
      wait_busy(1'b0, n);
      check("busy8", n, (m && KSA_BUILD) ? 1536 : 256);
      check("q8_empty", exp8_q.size(), 0);
      for (int k = 0; k < 256; k++) check("mem8", 32'(mem8[k]), mdl_s[k]);
      foreach (seen[k]) seen[k] = 0;
      for (int k = 0; k < 256; k++) seen[mem8[k]]++;
      dup = 0;
      foreach (seen[k]) if (seen[k] != 1) dup++;
      check("perm8", dup, 0);
   endtask

   task automatic run4(input bit m, input logic [3:0] k);
      int ks [3];
      int n = 0;
      while (rdy4 !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      ks = '{int'(k), 0, 0};
      ksa_model(16, 1, ks, m && KSA_BUILD);
      foreach (mdl_wr[x]) exp4_q.push_back(mdl_wr[x]);
      mode4 = m;
      key4  = k;
      en4   = 1'b1;
      @(posedge clk);
      #1;
      en4 = 1'b0;
      wait_busy(1'b1, n);
      check("busy4", n, (m && KSA_BUILD) ? 96 : 16);
      check("q4_empty", exp4_q.size(), 0);
      for (int x = 0; x < 16; x++) check("mem4", 32'(mem4[x]), mdl_s[x]);
   endtask

   initial begin
      int n1, n2;
      rst = 1'b1; en = 1'b0; mode = 1'b0; key = '0;
      en4 = 1'b0; mode4 = 1'b0; key4 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rdy", 32'(rdy), 1);
      check("rst_wren", 32'(wren), 0);
      check("rst_addr", 32'(addr), 0);
      check("rst_wrdata", 32'(wrdata), 0);
      check("rst_rdy4", 32'(rdy4), 1);
      check("rst_wren4", 32'(wren4), 0);
      rst = 1'b0;

      // Identity fill, then the reference key, then random requests.
      start8(1'b0, 24'($urandom), 1'b0);
      finish8(1'b0);
      start8(1'b1, 24'h00033C, 1'b0);
      finish8(1'b1);
      for (int r = 0; r < 2; r++) begin
         bit m;
         m = 1'($urandom_range(0, 1));
         start8(m, 24'($urandom), 1'b0);
         finish8(m);
      end

      // Small instance: all-zero single-symbol key forces i==j swaps.
      run4(1'b1, 4'h0);
      run4(1'b1, 4'($urandom));
      run4(1'b0, 4'($urandom));

      // en held high: one run per rdy window, next run starts as rdy rises.
      start8(1'b0, 24'($urandom), 1'b1);
      foreach (mdl_wr[x]) exp8_q.push_back(mdl_wr[x]);
      wait_busy(1'b0, n1);
      check("hold_busy1", n1, 256);
      @(posedge clk);
      #1;
      en = 1'b0;
      wait_busy(1'b0, n2);
      check("hold_busy2", n2, 256);
      repeat (5) @(negedge clk);
      check("hold_idle", 32'(rdy), 1);
      check("hold_q_empty", exp8_q.size(), 0);

      // Reset in the middle of a KSA run aborts it; a new request restarts cleanly.
      start8(1'b1, 24'($urandom), 1'b0);
      repeat (300) @(posedge clk);
      #1;
      rst = 1'b1;
      exp8_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_rdy", 32'(rdy), 1);
      check("abort_wren", 32'(wren), 0);
      check("abort_addr", 32'(addr), 0);
      start8(1'b0, 24'($urandom), 1'b0);
      finish8(1'b0);

      check("end_q8_empty", exp8_q.size(), 0);
      check("end_q4_empty", exp4_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not complete (checks=%0d)", n_chk);
      $fatal(1, "timeout");
   end

endmodule
